// File: rtl/gpio_mult_sched.sv
// -----------------------------------------------------------------------------
// gpio_mult_sched
//
// Round-robin scheduler that shares one iterative 24x24 shift-add multiplier
// and a popcount unit between two requesters. One requester is granted at a
// time. The scheduler latches that requester's operands and runs 24 multiply
// steps, then one popcount step, then signals completion.
//
// Ports:
//   clk       in   1      system clock, all state on rising edge
//   n_reset   in   1      asynchronous active-low reset
//   req       in   2      request per requester (bit 0 = requester 0)
//   a0, b0    in   24     operands of requester 0
//   a1, b1    in   24     operands of requester 1
//   ack       out  2      one-cycle grant pulse; operands captured
//   done      out  2      one-cycle completion pulse to the granted requester
//   result    out  32     product bits [31:0], held until next completion
//   valid     out  1      1 when product bits [47:32] are all zero
//   ones      out  6      popcount of result (0..32)
//   busy      out  1      high in every state except IDLE
//   op_count  out  CNT_W  completed operations, wraps
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module gpio_mult_sched #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [1:0]       req,
    input  logic [23:0]      a0,
    input  logic [23:0]      b0,
    input  logic [23:0]      a1,
    input  logic [23:0]      b1,
    output logic [1:0]       ack,
    output logic [1:0]       done,
    output logic [31:0]      result,
    output logic             valid,
    output logic [5:0]       ones,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_r;
    logic [23:0] a_r;
    logic [23:0] b_r;
    logic [47:0] acc_r;
    logic [4:0]  bit_idx_r;
    // Requester granted most recently; it also identifies the requester that
    // owns the operation in flight, so done is routed from it.
    logic        last_g_r;

    logic        winner_s;
    logic [47:0] addend_s;

    // Count the set bits of a 32-bit word.
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    // Arbitration: a lone request wins outright; on a tie the requester that
    // was not granted last time wins.
    always_comb begin
        winner_s = 1'b0;
        if (req == 2'b11) begin
            winner_s = ~last_g_r;
        end else if (req[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Partial product for the current multiplier bit.
    always_comb begin
        addend_s = 48'd0;
        if (b_r[bit_idx_r]) begin
            addend_s = {24'd0, a_r} << bit_idx_r;
        end else begin
            addend_s = 48'd0;
        end
    end

    // Scheduler FSM, datapath and registered outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r   <= IDLE;
            a_r       <= 24'd0;
            b_r       <= 24'd0;
            acc_r     <= 48'd0;
            bit_idx_r <= 5'd0;
            last_g_r  <= 1'b1;
            ack       <= 2'b00;
            done      <= 2'b00;
            result    <= 32'd0;
            valid     <= 1'b1;
            ones      <= 6'd0;
            busy      <= 1'b0;
            op_count  <= '0;
        end else begin
            // ack and done are single-cycle pulses unless re-asserted below.
            ack  <= 2'b00;
            done <= 2'b00;
            case (state_r)
                IDLE: begin
                    if (req != 2'b00) begin
                        a_r       <= winner_s ? a1 : a0;
                        b_r       <= winner_s ? b1 : b0;
                        acc_r     <= 48'd0;
                        bit_idx_r <= 5'd0;
                        ack       <= winner_s ? 2'b10 : 2'b01;
                        last_g_r  <= winner_s;
                        busy      <= 1'b1;
                        state_r   <= MULT;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                MULT: begin
                    acc_r <= acc_r + addend_s;
                    if (bit_idx_r == 5'd23) begin
                        state_r <= COUNT;
                    end else begin
                        bit_idx_r <= bit_idx_r + 5'd1;
                        state_r   <= MULT;
                    end
                end
                COUNT: begin
                    result  <= acc_r[31:0];
                    valid   <= (acc_r[47:32] == 16'd0);
                    ones    <= popcount32(acc_r[31:0]);
                    state_r <= DONE;
                end
                DONE: begin
                    done     <= last_g_r ? 2'b10 : 2'b01;
                    op_count <= op_count + CNT_W'(1);
                    busy     <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_mult_sched.sv
// -----------------------------------------------------------------------------
// tb_gpio_mult_sched
//
// Self-checking bench for gpio_mult_sched. A timeline model (grant edge, then
// results 25 edges later, then completion 26 edges later) predicts every
// output each cycle. Directed sequences pin the model with literal values, and
// a randomized phase exercises arbitration, operand changes and resets.
// A second instance with a 3-bit counter shows the op_count wrap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_gpio_mult_sched;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [23:0] a0 = 24'd0, b0 = 24'd0, a1 = 24'd0, b1 = 24'd0;

    logic [1:0]  ack, done;
    logic [31:0] result;
    logic        valid, busy;
    logic [5:0]  ones;
    logic [15:0] op_count;

    logic [1:0]  ack_w, done_w;
    logic [31:0] result_w;
    logic        valid_w, busy_w;
    logic [5:0]  ones_w;
    logic [2:0]  op_count_w;

    int total = 0;
    int bad   = 0;

    gpio_mult_sched #(.CNT_W(16)) dut (
        .clk(clk), .n_reset(n_reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack), .done(done), .result(result), .valid(valid),
        .ones(ones), .busy(busy), .op_count(op_count)
    );

    gpio_mult_sched #(.CNT_W(3)) dut_w (
        .clk(clk), .n_reset(n_reset), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack_w), .done(done_w), .result(result_w), .valid(valid_w),
        .ones(ones_w), .busy(busy_w), .op_count(op_count_w)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [1:0]  m_ack = 2'b00, m_done = 2'b00;
    logic [31:0] m_result = 32'd0;
    logic        m_valid = 1'b1, m_busy = 1'b0;
    logic [5:0]  m_ones = 6'd0;
    int          m_cnt = 0;
    logic        m_last = 1'b1, m_g = 1'b0, m_active = 1'b0;
    int          m_t = 0;
    logic [47:0] m_prod = 48'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ack = 2'b00; m_done = 2'b00; m_result = 32'd0; m_valid = 1'b1;
        m_ones = 6'd0; m_busy = 1'b0; m_cnt = 0; m_last = 1'b1;
        m_active = 1'b0; m_t = 0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_step();
        if (!n_reset) begin
            model_reset();
        end else begin
            m_ack  = 2'b00;
            m_done = 2'b00;
            if (!m_active) begin
                if (req != 2'b00) begin
                    m_g      = (req == 2'b11) ? ~m_last : req[1];
                    m_prod   = m_g ? ({24'd0, a1} * {24'd0, b1}) : ({24'd0, a0} * {24'd0, b0});
                    m_last   = m_g;
                    m_ack    = m_g ? 2'b10 : 2'b01;
                    m_active = 1'b1;
                    m_t      = 0;
                    m_busy   = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t == 25) begin
                    m_result = m_prod[31:0];
                    m_valid  = (m_prod[47:32] == 16'd0);
                    m_ones   = 6'($countones(m_prod[31:0]));
                end
                if (m_t == 26) begin
                    m_done   = m_g ? 2'b10 : 2'b01;
                    m_cnt++;
                    m_active = 1'b0;
                    m_busy   = 1'b0;
                end
            end
        end
    endtask

    // Model advances on each rising edge; DUT is compared mid-cycle.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!n_reset) model_reset();
            chk("ack",      64'(ack),        64'(m_ack));
            chk("done",     64'(done),       64'(m_done));
            chk("result",   64'(result),     64'(m_result));
            chk("valid",    64'(valid),      64'(m_valid));
            chk("ones",     64'(ones),       64'(m_ones));
            chk("busy",     64'(busy),       64'(m_busy));
            chk("op_count", 64'(op_count),   64'(m_cnt % 65536));
            chk("op_cnt_w", 64'(op_count_w), 64'(m_cnt % 8));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        req     = 2'b00;
        tick();
        tick();
        n_reset = 1'b1;
        tick();
    endtask

    // Issue one request, check grant, latency and literal results.
    task automatic run_op(input logic [1:0] r, input logic [23:0] xa0, input logic [23:0] xb0,
                          input logic [23:0] xa1, input logic [23:0] xb1, input logic change_mid,
                          input logic [1:0] exp_g, input logic [31:0] exp_res,
                          input logic exp_valid, input logic [5:0] exp_ones);
        int n;
        logic seen;
        a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1; req = r;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk("grant_seen", 64'(seen), 64'(1));
        chk("grant_who",  64'(ack),  64'(exp_g));
        req = 2'b00;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (change_mid && n == 5) begin
                a0 = 24'h7;
                a1 = 24'h7;
            end
            if (done != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen",    64'(seen),   64'(1));
        chk("done_latency", 64'(n),      64'(26));
        chk("done_who",     64'(done),   64'(exp_g));
        chk("lit_result",   64'(result), 64'(exp_res));
        chk("lit_valid",    64'(valid),  64'(exp_valid));
        chk("lit_ones",     64'(ones),   64'(exp_ones));
    endtask

    task automatic wait_done(input logic [31:0] exp_res, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 64'(seen), 64'(1));
        chk(name, 64'(result), 64'(exp_res));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        tick();
        chk("rst_result", 64'(result),   64'(0));
        chk("rst_valid",  64'(valid),    64'(1));
        chk("rst_busy",   64'(busy),     64'(0));
        chk("rst_cnt",    64'(op_count), 64'(0));
        do_reset();

        // Basic multiply, then overflow cases and zero operand.
        run_op(2'b01, 24'd3, 24'd5, 24'd0, 24'd0, 1'b0, 2'b01, 32'd15, 1'b1, 6'd4);
        chk("basic_cnt", 64'(op_count), 64'(1));
        run_op(2'b10, 24'd0, 24'd0, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 2'b10, 32'hFE000001, 1'b0, 6'd8);
        run_op(2'b01, 24'h10000, 24'h10000, 24'd0, 24'd0, 1'b0, 2'b01, 32'd0, 1'b0, 6'd0);
        run_op(2'b01, 24'd0, 24'hFFFFFF, 24'd0, 24'd0, 1'b0, 2'b01, 32'd0, 1'b1, 6'd0);

        // Operand change mid-operation has no effect.
        run_op(2'b01, 24'd3, 24'd5, 24'd0, 24'd0, 1'b1, 2'b01, 32'd15, 1'b1, 6'd4);

        // Simultaneous requests held continuously alternate 0,1,0.
        do_reset();
        a0 = 24'd2; b0 = 24'd2; a1 = 24'd3; b1 = 24'd3; req = 2'b11;
        wait_done(32'd4, "rr_first");
        wait_done(32'd9, "rr_second");
        wait_done(32'd4, "rr_third");
        req = 2'b00;
        for (int i = 0; i < 30; i++) tick();

        // Reset mid-MULT aborts the operation.
        do_reset();
        run_op(2'b01, 24'd3, 24'd5, 24'd0, 24'd0, 1'b0, 2'b01, 32'd15, 1'b1, 6'd4);
        a0 = 24'd6; b0 = 24'd7; req = 2'b01;
        tick();
        req = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        n_reset = 1'b0;
        tick();
        chk("abort_busy",   64'(busy),     64'(0));
        chk("abort_result", 64'(result),   64'(0));
        chk("abort_valid",  64'(valid),    64'(1));
        chk("abort_ones",   64'(ones),     64'(0));
        chk("abort_cnt",    64'(op_count), 64'(0));
        n_reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done != 2'b00) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'(0));

        // Narrow counter wraps after 8 operations.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            run_op(2'b01, 24'd1, 24'd1, 24'd0, 24'd0, 1'b0, 2'b01, 32'd1, 1'b1, 6'd1);
        end
        chk("wrap_narrow", 64'(op_count_w), 64'(0));
        chk("wrap_wide",   64'(op_count),   64'(8));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) req = 2'b00;
            else if (sel < 6) req = 2'b01;
            else if (sel < 8) req = 2'b10;
            else req = 2'b11;
            a0 = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            b0 = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
            a1 = 24'($urandom);
            b1 = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
            n_reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        n_reset = 1'b1;
        req = 2'b00;
        for (int i = 0; i < 30; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_mult_sched.md
# gpio_mult_sched

Round-robin scheduler that shares one iterative 24×24 shift-add multiplier and popcount unit between two requesters. It sits between the GPIO emulator bus-register front end and the multiply datapath. It grants one requester at a time, latches that requester's operands, and sequences the multiply over 24 cycles, then the popcount. It returns the 32-bit result, an overflow-free flag and the ones count with a per-requester completion pulse.

## Interface
Parameters:
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  system clock, all state on rising edge
- n_reset  in  1  asynchronous, active-low reset
- req  in  2  request per requester (bit 0 = requester 0)
- a0, b0  in  24 each  operands of requester 0
- a1, b1  in  24 each  operands of requester 1
- ack  out  2  one-cycle grant pulse; operands captured
- done  out  2  one-cycle completion pulse to granted requester
- result  out  32  product bits [31:0], held until next completion
- valid  out  1  1 when product bits [47:32] are all zero
- ones  out  6  popcount of result (0..32)
- busy  out  1  high in every state except IDLE
- op_count  out  CNT_W  completed operations, wraps

## Operation
- Reset (async assert) forces the following values:
  - state=IDLE; ack=0, done=0, result=0, valid=1, ones=0, busy=0, op_count=0.
  - Internal accumulator=0, bit index=0, last-grant pointer=1, so requester 0 wins the first tie.
- FSM states: IDLE, MULT, COUNT, DONE.
- IDLE, with req≠0 at an edge:
  - Pick the winner g: if only one req bit is set, that one. If both are set, the requester other than last-grant.
  - Latch a_g and b_g into internal A and B, clear the 48-bit accumulator and bit index.
  - Set ack[g] for one cycle, record g in last-grant, go to MULT.
- MULT, one edge per bit i=0..23:
  - If B[i]=1, accumulator += {24'b0,A} << i.
  - After i=23 is processed, go to COUNT.
- COUNT, one edge:
  - Register result=acc[31:0], valid=(acc[47:32]==0), ones=popcount(acc[31:0]).
  - Go to DONE.
- DONE, one edge:
  - Assert done[g] for one cycle, op_count+=1 (modulo 2^CNT_W), go to IDLE.
- Arithmetic: the full 48-bit product is kept internally. Only [31:0] is exported; overflow is reported solely through valid=0.
- Operand inputs are ignored outside the IDLE grant edge. Changes during an operation have no effect.
- req deasserted before it is sampled in IDLE: no operation. req held high after done: treated as a new request.
- result, valid and ones change only at the COUNT edge. They are stable from then through the next operation's COUNT edge.

## Timing
- Grant edge k (IDLE, req seen): ack[g]=1 during cycle k..k+1.
- MULT edges k+1..k+24. The COUNT edge at k+25 updates result, valid and ones.
- DONE edge k+26: done[g]=1 during cycle k+26..k+27, op_count updated.
- Next grant possible at edge k+27, so throughput is one operation per 27 cycles.
- busy rises after edge k and falls after edge k+26.
- ack and done are never asserted simultaneously. At most one bit of each is set.
- Reset mid-operation: the operation is aborted immediately. No done pulse, op_count not incremented, last-grant returns to 1.

## Test plan
- **Basic multiply:** reset, then req=01 with a0=3, b0=5.
  - ack=01 one cycle after the grant edge.
  - done=01 exactly 26 cycles after the grant edge, with result=15, valid=1, ones=4, op_count=1.
- **Overflow, full range:** req=10 with a1=b1=0xFFFFFF.
  - result=0xFE000001, valid=0, ones=8.
- **Overflow, boundary:** a0=b0=0x10000.
  - result=0, valid=0, ones=0.
- **Zero operand:** a0=0, b0=0xFFFFFF.
  - result=0, valid=1, ones=0.
- **Simultaneous requests:** req=11 held continuously after reset, a0=2,b0=2, a1=3,b1=3.
  - Grants alternate 0,1,0,…; done pulses return 4 then 9 then 4.
- **Operand change and reset abort:**
  - Change a0 mid-MULT: the result still uses the latched value.
  - Pulse n_reset low during MULT: all outputs return to their reset values, no done pulse.
  - Force op_count to 0xFFFF and complete one operation: op_count wraps to 0.
